multicycle_ctrl_fsm: RTL and testbench
======================================

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles, legal range 1..7.
REQ-002 Parameter MULDIV_CYC, default 32: mult/div busy cycles, legal range 1..63.
REQ-003 Parameters EXC_OPC, EXC_OVF, EXC_DIV0 (32 bit), defaults 32'd253, 32'd254, 32'd255: exception vector addresses.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on rising clk edge.
REQ-006 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0].
REQ-007 overflowflag  in  1  ALU signed overflow; divby0flag  in  1  divider zero-divisor flag; zeroflag  in  1  ALU compare result for branches.
REQ-008 PCWrite, PCWriteCond, IorD, WR, IRWrite, RegWrite, ALUSrcA, AluOutLoad, EPCWrite, MulDivStart, ResetTrigger  out  1 each  datapath strobes and mux selects.
REQ-009 RegDest  out  2 (0 rt, 1 rd, 2 r31); MemToReg  out  3 (0 ALUOut, 1 MDR, 2 HI, 3 LO, 4 PC, 5 shifter); ALUSrcB  out  3 (0 B, 1 const 4, 2 sign-ext imm, 3 imm<<2); PCSource  out  3 (0 ALU, 1 ALUOut, 2 jump target, 3 EPC, 4 ExceptionAdress).
REQ-010 ControlType  out  5  ALU op (1 add, 2 sub, 3 and, 4 or, 7 slt); SizeHandler  out  3 (0 word, 1 half, 2 byte); ExceptionAdress  out  32.

Function
REQ-011 Controller SHALL be an explicit registered FSM; outputs SHALL be a pure function of state, counter and decoded instruction class; no timing control inside combinational logic.
REQ-012 States: RST, FETCH, DECODE, EXEC, MEMACC, WB, MULDIV, EXC_EPC, EXC_JMP.
REQ-013 Every output SHALL default to 0 in any state unless listed below.
REQ-014 RST: ResetTrigger=1 for exactly one cycle after rst_n rises, then FETCH.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=1, ControlType=1; holds for MEM_LAT cycles via a 3-bit counter; in the last cycle IRWrite=1, PCSource=0, PCWrite=1; then DECODE.
REQ-016 DECODE (1 cycle): ALUSrcA=0, ALUSrcB=3, ControlType=1, AluOutLoad=1; unknown opcode or R-type funct -> EXC_EPC with ExceptionAdress=EXC_OPC, else EXEC.
REQ-017 R-ALU (add 32, sub 34, and 36, or 37, slt 42): EXEC ALUSrcA=1, ALUSrcB=0, op per REQ-010, AluOutLoad=1; WB MemToReg=0, RegDest=1, RegWrite=1.
REQ-018 I-ALU (addi 8, addiu 9, slti 10): as REQ-017 but ALUSrcB=2, RegDest=0.
REQ-019 Overflow: for add, sub, addi only, overflowflag=1 in EXEC -> EXC_EPC with EXC_OVF, and RegWrite SHALL never assert for that instruction; addiu ignores overflowflag.
REQ-020 Shifts (funct 0, 2, 3, 4, 7) and lui 15: EXEC 1 cycle, WB MemToReg=5.
REQ-021 Branches (beq 4, bne 5, ble 6, bgt 7): EXEC ALUSrcA=1, ALUSrcB=0, ControlType=2, PCSource=1, PCWriteCond=1; then FETCH, no WB.
REQ-022 j 2: EXEC PCSource=2, PCWrite=1, then FETCH; jal 3: same cycle adds RegDest=2, MemToReg=4, RegWrite=1; jr 8: EXEC PCSource=0, ALUSrcA=1, ControlType=0, PCWrite=1; rte 19: EXEC PCSource=3, PCWrite=1.
REQ-023 Loads (lw 35, lh 33, lb 32): EXEC address calc (ALUSrcA=1, ALUSrcB=2, ControlType=1, AluOutLoad=1); MEMACC IorD=1 for MEM_LAT cycles; WB MemToReg=1, RegDest=0, RegWrite=1, SizeHandler per REQ-010.
REQ-024 Stores (sw 43, sh 41, sb 40): EXEC address calc; MEMACC IorD=1, MEM_LAT read cycles, then one cycle WR=1 with SizeHandler set; then FETCH.
REQ-025 mult 24 / div 26: EXEC MulDivStart=1 for one cycle; MULDIV holds for MULDIV_CYC cycles via a 6-bit counter, then FETCH; div with divby0flag=1 on the first MULDIV cycle -> EXC_EPC with EXC_DIV0 immediately.
REQ-026 mfhi 16 / mflo 18: WB only, MemToReg=2/3, RegDest=1, RegWrite=1.
REQ-027 EXC_EPC: ALUSrcA=0, ALUSrcB=1, ControlType=2, EPCWrite=1 (EPC := PC-4); EXC_JMP: PCSource=4, PCWrite=1, ExceptionAdress held stable across both cycles; then FETCH.
REQ-028 If overflow and an invalid opcode coincide, invalid opcode wins; only one exception per instruction.

Reset
REQ-029 rst_n=0 at any clock edge, including mid-MEMACC, mid-MULDIV or mid-exception, SHALL force state RST, clear both counters and drive every output to 0 on the next cycle; no partial write (WR, RegWrite, PCWrite, EPCWrite) may follow.

Verification
REQ-030 Reset then add (op 0, funct 32), MEM_LAT=2, overflowflag=0 -> IRWrite at cycle 2, RegWrite=1 with RegDest=1 at cycle 5, then FETCH.
REQ-031 addi with overflowflag=1 -> EPCWrite=1, then PCWrite=1 with PCSource=4 and ExceptionAdress=254; RegWrite stays 0.
REQ-032 div with divby0flag=1 -> exception to 255 within 2 cycles after MulDivStart; with flag=0 and MULDIV_CYC=32 -> FETCH after exactly 32 MULDIV cycles.
REQ-033 opcode 6'd63 -> EXC_EPC at the cycle after DECODE, ExceptionAdress=253.
REQ-034 sb -> exactly one WR=1 cycle with SizeHandler=2; rst_n=0 during MEMACC of lw -> no RegWrite, RST next cycle, ResetTrigger one cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Control unit for a multicycle MIPS-like datapath: a Moore FSM whose strobes
// depend only on the current state, the two phase counters and the instruction class latched in DECODE.
module multicycle_ctrl_fsm #(
  parameter int          MEM_LAT    = 2,
  parameter int          MULDIV_CYC = 32,
  parameter logic [31:0] EXC_OPC    = 32'd253,
  parameter logic [31:0] EXC_OVF    = 32'd254,
  parameter logic [31:0] EXC_DIV0   = 32'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        overflowflag,
  input  logic        divby0flag,
  input  logic        zeroflag,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        WR,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        AluOutLoad,
  output logic        EPCWrite,
  output logic        MulDivStart,
  output logic        ResetTrigger,
  output logic [1:0]  RegDest,
  output logic [2:0]  MemToReg,
  output logic [2:0]  ALUSrcB,
  output logic [2:0]  PCSource,
  output logic [4:0]  ControlType,
  output logic [2:0]  SizeHandler,
  output logic [31:0] ExceptionAdress
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEMACC, S_WB, S_MULDIV, S_EXC_EPC, S_EXC_JMP
  } state_t;

  typedef enum logic [3:0] {
    C_BAD, C_RALU, C_IALU, C_SHIFT, C_LUI, C_BRANCH, C_J, C_JAL,
    C_JR, C_RTE, C_LOAD, C_STORE, C_MULT, C_DIV, C_MFHI, C_MFLO
  } cls_t;

  localparam logic [2:0] MEM_LAST  = 3'(MEM_LAT - 1);
  localparam logic [2:0] MEM_WRITE = 3'(MEM_LAT);
  localparam logic [5:0] MD_LAST   = 6'(MULDIV_CYC - 1);

  state_t      state_r, state_s;
  cls_t        cls_r, dec_cls_s;
  logic [4:0]  alu_op_r, dec_op_s;
  logic        ovf_chk_r, dec_ovf_s;
  logic [2:0]  size_r, dec_size_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [5:0]  mdcnt_r, mdcnt_s;
  logic [31:0] exc_r, exc_s;

  // zeroflag is resolved in the datapath through PCWriteCond
  logic unused_s;
  assign unused_s = zeroflag;

  // Instruction decode from the IR fields
  always_comb begin
    dec_cls_s  = C_BAD;
    dec_op_s   = 5'd0;
    dec_ovf_s  = 1'b0;
    dec_size_s = 3'd0;
    if (opcode == 6'd0) begin
      case (funct)
        6'd32: begin dec_cls_s = C_RALU; dec_op_s = 5'd1; dec_ovf_s = 1'b1; end
        6'd34: begin dec_cls_s = C_RALU; dec_op_s = 5'd2; dec_ovf_s = 1'b1; end
        6'd36: begin dec_cls_s = C_RALU; dec_op_s = 5'd3; end
        6'd37: begin dec_cls_s = C_RALU; dec_op_s = 5'd4; end
        6'd42: begin dec_cls_s = C_RALU; dec_op_s = 5'd7; end
        6'd0, 6'd2, 6'd3, 6'd4, 6'd7: dec_cls_s = C_SHIFT;
        6'd8:  dec_cls_s = C_JR;
        6'd19: dec_cls_s = C_RTE;
        6'd16: dec_cls_s = C_MFHI;
        6'd18: dec_cls_s = C_MFLO;
        6'd24: dec_cls_s = C_MULT;
        6'd26: dec_cls_s = C_DIV;
        default: dec_cls_s = C_BAD;
      endcase
    end else begin
      case (opcode)
        6'd8:  begin dec_cls_s = C_IALU; dec_op_s = 5'd1; dec_ovf_s = 1'b1; end
        6'd9:  begin dec_cls_s = C_IALU; dec_op_s = 5'd1; end
        6'd10: begin dec_cls_s = C_IALU; dec_op_s = 5'd7; end
        6'd15: dec_cls_s = C_LUI;
        6'd4, 6'd5, 6'd6, 6'd7: dec_cls_s = C_BRANCH;
        6'd2:  dec_cls_s = C_J;
        6'd3:  dec_cls_s = C_JAL;
        6'd35: begin dec_cls_s = C_LOAD;  dec_size_s = 3'd0; end
        6'd33: begin dec_cls_s = C_LOAD;  dec_size_s = 3'd1; end
        6'd32: begin dec_cls_s = C_LOAD;  dec_size_s = 3'd2; end
        6'd43: begin dec_cls_s = C_STORE; dec_size_s = 3'd0; end
        6'd41: begin dec_cls_s = C_STORE; dec_size_s = 3'd1; end
        6'd40: begin dec_cls_s = C_STORE; dec_size_s = 3'd2; end
        default: dec_cls_s = C_BAD;
      endcase
    end
  end

  // State, counters, exception vector and the class latched in DECODE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_RST;
      cnt_r     <= 3'd0;
      mdcnt_r   <= 6'd0;
      exc_r     <= 32'd0;
      cls_r     <= C_BAD;
      alu_op_r  <= 5'd0;
      ovf_chk_r <= 1'b0;
      size_r    <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mdcnt_r <= mdcnt_s;
      exc_r   <= exc_s;
      if (state_r == S_DECODE) begin
        cls_r     <= dec_cls_s;
        alu_op_r  <= dec_op_s;
        ovf_chk_r <= dec_ovf_s;
        size_r    <= dec_size_s;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mdcnt_s = mdcnt_r;
    exc_s   = exc_r;
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; WR = 1'b0;
    IRWrite = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; AluOutLoad = 1'b0;
    EPCWrite = 1'b0; MulDivStart = 1'b0; ResetTrigger = 1'b0;
    RegDest = 2'd0; MemToReg = 3'd0; ALUSrcB = 3'd0; PCSource = 3'd0;
    ControlType = 5'd0; SizeHandler = 3'd0; ExceptionAdress = 32'd0;
    case (state_r)
      // cnt_r==0 is the silent cycle in reset; cnt_r==1 is the single trigger cycle after release
      S_RST: begin
        if (cnt_r == 3'd0) begin
          cnt_s = 3'd1;
        end else begin
          ResetTrigger = 1'b1;
          cnt_s        = 3'd0;
          state_s      = S_FETCH;
        end
      end
      S_FETCH: begin
        ALUSrcB     = 3'd1;
        ControlType = 5'd1;
        if (cnt_r == MEM_LAST) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          cnt_s   = 3'd0;
          state_s = S_DECODE;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      S_DECODE: begin
        ALUSrcB     = 3'd3;
        ControlType = 5'd1;
        AluOutLoad  = 1'b1;
        if (dec_cls_s == C_BAD) begin
          exc_s   = EXC_OPC;
          state_s = S_EXC_EPC;
        end else if (dec_cls_s == C_MFHI || dec_cls_s == C_MFLO) begin
          state_s = S_WB;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        state_s = S_FETCH;
        cnt_s   = 3'd0;
        case (cls_r)
          C_RALU, C_IALU: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = (cls_r == C_RALU) ? 3'd0 : 3'd2;
            ControlType = alu_op_r;
            AluOutLoad  = 1'b1;
            if (ovf_chk_r && overflowflag) begin
              exc_s   = EXC_OVF;
              state_s = S_EXC_EPC;
            end else begin
              state_s = S_WB;
            end
          end
          C_SHIFT, C_LUI: state_s = S_WB;
          C_BRANCH: begin
            ALUSrcA = 1'b1; ControlType = 5'd2; PCSource = 3'd1; PCWriteCond = 1'b1;
          end
          C_J:   begin PCSource = 3'd2; PCWrite = 1'b1; end
          C_JAL: begin
            PCSource = 3'd2; PCWrite = 1'b1;
            RegDest = 2'd2; MemToReg = 3'd4; RegWrite = 1'b1;
          end
          C_JR:  begin PCSource = 3'd0; ALUSrcA = 1'b1; ControlType = 5'd0; PCWrite = 1'b1; end
          C_RTE: begin PCSource = 3'd3; PCWrite = 1'b1; end
          C_LOAD, C_STORE: begin
            ALUSrcA = 1'b1; ALUSrcB = 3'd2; ControlType = 5'd1; AluOutLoad = 1'b1;
            state_s = S_MEMACC;
          end
          C_MULT, C_DIV: begin
            MulDivStart = 1'b1;
            mdcnt_s     = 6'd0;
            state_s     = S_MULDIV;
          end
          default: state_s = S_FETCH;
        endcase
      end
      // Stores spend one extra MEMACC cycle (cnt_r==MEM_LAT) issuing the write
      S_MEMACC: begin
        IorD = 1'b1;
        if (cls_r == C_STORE && cnt_r == MEM_WRITE) begin
          WR          = 1'b1;
          SizeHandler = size_r;
          cnt_s       = 3'd0;
          state_s     = S_FETCH;
        end else if (cls_r != C_STORE && cnt_r == MEM_LAST) begin
          cnt_s   = 3'd0;
          state_s = S_WB;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      S_WB: begin
        cnt_s   = 3'd0;
        state_s = S_FETCH;
        case (cls_r)
          C_RALU:  begin RegWrite = 1'b1; RegDest = 2'd1; end
          C_IALU:  begin RegWrite = 1'b1; RegDest = 2'd0; end
          C_SHIFT: begin RegWrite = 1'b1; RegDest = 2'd1; MemToReg = 3'd5; end
          C_LUI:   begin RegWrite = 1'b1; RegDest = 2'd0; MemToReg = 3'd5; end
          C_LOAD:  begin RegWrite = 1'b1; MemToReg = 3'd1; SizeHandler = size_r; end
          C_MFHI:  begin RegWrite = 1'b1; RegDest = 2'd1; MemToReg = 3'd2; end
          C_MFLO:  begin RegWrite = 1'b1; RegDest = 2'd1; MemToReg = 3'd3; end
          default: RegWrite = 1'b0;
        endcase
      end
      S_MULDIV: begin
        if (cls_r == C_DIV && mdcnt_r == 6'd0 && divby0flag) begin
          exc_s   = EXC_DIV0;
          state_s = S_EXC_EPC;
        end else if (mdcnt_r == MD_LAST) begin
          cnt_s   = 3'd0;
          state_s = S_FETCH;
        end else begin
          mdcnt_s = mdcnt_r + 6'd1;
        end
      end
      S_EXC_EPC: begin
        ALUSrcB         = 3'd1;
        ControlType     = 5'd2;
        EPCWrite        = 1'b1;
        ExceptionAdress = exc_r;
        state_s         = S_EXC_JMP;
      end
      S_EXC_JMP: begin
        PCSource        = 3'd4;
        PCWrite         = 1'b1;
        ExceptionAdress = exc_r;
        cnt_s           = 3'd0;
        state_s         = S_FETCH;
      end
      default: state_s = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// output script from the ISA rules and compared against the controller outputs.
module tb_multicycle_ctrl_fsm;

  localparam int MEM_LAT    = 2;
  localparam int MULDIV_CYC = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic overflowflag, divby0flag, zeroflag;
  logic PCWrite, PCWriteCond, IorD, WR, IRWrite, RegWrite, ALUSrcA, AluOutLoad;
  logic EPCWrite, MulDivStart, ResetTrigger;
  logic [1:0]  RegDest;
  logic [2:0]  MemToReg, ALUSrcB, PCSource, SizeHandler;
  logic [4:0]  ControlType;
  logic [31:0] ExceptionAdress;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_LAT(MEM_LAT), .MULDIV_CYC(MULDIV_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .overflowflag(overflowflag), .divby0flag(divby0flag), .zeroflag(zeroflag),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .WR(WR),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .AluOutLoad(AluOutLoad),
    .EPCWrite(EPCWrite), .MulDivStart(MulDivStart), .ResetTrigger(ResetTrigger),
    .RegDest(RegDest), .MemToReg(MemToReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ControlType(ControlType), .SizeHandler(SizeHandler), .ExceptionAdress(ExceptionAdress)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, wr, irw, regw, srca, aluout, epcw, mds, rstt;
    logic [1:0]  regdest;
    logic [2:0]  memtoreg, srcb, pcsrc;
    logic [4:0]  ct;
    logic [2:0]  size;
    logic [31:0] exc;
  } outs_t;

  outs_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int r_fn [16] = '{32, 34, 36, 37, 42, 0, 2, 3, 4, 7, 8, 19, 16, 18, 24, 26};
  int i_op [16] = '{8, 9, 10, 15, 4, 5, 6, 7, 2, 3, 35, 33, 32, 43, 41, 40};

  function automatic outs_t observed();
    return {PCWrite, PCWriteCond, IorD, WR, IRWrite, RegWrite, ALUSrcA, AluOutLoad,
            EPCWrite, MulDivStart, ResetTrigger, RegDest, MemToReg, ALUSrcB, PCSource,
            ControlType, SizeHandler, ExceptionAdress};
  endfunction

  task automatic check_eq(input string tag, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exc(input logic [31:0] a);
    outs_t v;
    v = '0; v.srcb = 3'd1; v.ct = 5'd2; v.epcw = 1'b1; v.exc = a; q.push_back(v);
    v = '0; v.pcsrc = 3'd4; v.pcw = 1'b1; v.exc = a; q.push_back(v);
  endtask

  // Expected cycle-by-cycle outputs of one instruction, starting at its first FETCH cycle
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic dz);
    outs_t v;
    bit r, ralu, ialu, shf, br, ld, st, md, mf, jmp, jr, rte;
    logic [4:0] alu;
    logic [2:0] sz;
    r    = (op == 6'd0);
    ralu = r && (fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
    ialu = op inside {6'd8, 6'd9, 6'd10};
    shf  = (r && (fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd7})) || op == 6'd15;
    br   = op inside {6'd4, 6'd5, 6'd6, 6'd7};
    ld   = op inside {6'd32, 6'd33, 6'd35};
    st   = op inside {6'd40, 6'd41, 6'd43};
    md   = r && (fn inside {6'd24, 6'd26});
    mf   = r && (fn inside {6'd16, 6'd18});
    jmp  = op inside {6'd2, 6'd3};
    jr   = r && fn == 6'd8;
    rte  = r && fn == 6'd19;
    alu  = ralu ? ((fn == 6'd32) ? 5'd1 : (fn == 6'd34) ? 5'd2 : (fn == 6'd36) ? 5'd3 :
                   (fn == 6'd37) ? 5'd4 : 5'd7)
                : ((op == 6'd10) ? 5'd7 : 5'd1);
    sz   = (op == 6'd35 || op == 6'd43) ? 3'd0 : (op == 6'd33 || op == 6'd41) ? 3'd1 : 3'd2;
    for (int i = 0; i < MEM_LAT; i++) begin
      v = '0; v.srcb = 3'd1; v.ct = 5'd1;
      if (i == MEM_LAT - 1) begin v.irw = 1'b1; v.pcw = 1'b1; end
      q.push_back(v);
    end
    v = '0; v.srcb = 3'd3; v.ct = 5'd1; v.aluout = 1'b1; q.push_back(v);
    if (!(ralu || ialu || shf || br || ld || st || md || mf || jmp || jr || rte)) begin
      push_exc(32'd253);
      return;
    end
    v = '0;
    if (mf) begin
      v.regw = 1'b1; v.regdest = 2'd1; v.memtoreg = (fn == 6'd16) ? 3'd2 : 3'd3;
      q.push_back(v);
    end else if (ralu || ialu) begin
      v.srca = 1'b1; v.srcb = ralu ? 3'd0 : 3'd2; v.ct = alu; v.aluout = 1'b1;
      q.push_back(v);
      if (ovf && ((r && (fn == 6'd32 || fn == 6'd34)) || op == 6'd8)) begin
        push_exc(32'd254);
      end else begin
        v = '0; v.regw = 1'b1; v.regdest = ralu ? 2'd1 : 2'd0; q.push_back(v);
      end
    end else if (shf) begin
      q.push_back(v);
      v.regw = 1'b1; v.memtoreg = 3'd5; v.regdest = r ? 2'd1 : 2'd0; q.push_back(v);
    end else if (br) begin
      v.srca = 1'b1; v.ct = 5'd2; v.pcsrc = 3'd1; v.pcwc = 1'b1; q.push_back(v);
    end else if (jmp) begin
      v.pcsrc = 3'd2; v.pcw = 1'b1;
      if (op == 6'd3) begin v.regdest = 2'd2; v.memtoreg = 3'd4; v.regw = 1'b1; end
      q.push_back(v);
    end else if (jr) begin
      v.srca = 1'b1; v.pcw = 1'b1; q.push_back(v);
    end else if (rte) begin
      v.pcsrc = 3'd3; v.pcw = 1'b1; q.push_back(v);
    end else if (ld || st) begin
      v.srca = 1'b1; v.srcb = 3'd2; v.ct = 5'd1; v.aluout = 1'b1; q.push_back(v);
      v = '0; v.iord = 1'b1;
      repeat (MEM_LAT) q.push_back(v);
      if (st) begin
        v.wr = 1'b1; v.size = sz; q.push_back(v);
      end else begin
        v = '0; v.regw = 1'b1; v.memtoreg = 3'd1; v.size = sz; q.push_back(v);
      end
    end else begin
      v.mds = 1'b1; q.push_back(v);
      v = '0;
      if (fn == 6'd26 && dz) begin
        q.push_back(v);
        push_exc(32'd255);
      end else begin
        repeat (MULDIV_CYC) q.push_back(v);
      end
    end
  endtask

  // cut>0: pull rst_n low after that many cycles; cut<0: pick a random cut point
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                           input logic dz, input int cut, input int idx);
    int n;
    outs_t v;
    q.delete();
    build(op, fn, ovf, dz);
    if (cut < 0) cut = $urandom_range(1, q.size() - 1);
    n = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      if (n == 0) begin
        opcode = op; funct = fn; overflowflag = ovf; divby0flag = dz;
      end
      zeroflag = 1'($urandom_range(0, 1));
      check_eq($sformatf("insn%0d op%0d fn%0d cyc%0d", idx, op, fn, n), observed(), q.pop_front());
      n++;
      if (cut > 0 && n == cut) begin
        rst_n = 1'b0;
        q.delete();
        @(posedge clk); #1;
        check_eq($sformatf("insn%0d reset_quiet", idx), observed(), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = '0; v.rstt = 1'b1;
        check_eq($sformatf("insn%0d reset_trigger", idx), observed(), v);
      end
    end
  endtask

  initial begin
    outs_t v;
    logic [5:0] op, fn;
    int k;
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0;
    overflowflag = 1'b0; divby0flag = 1'b0; zeroflag = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", observed(), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v = '0; v.rstt = 1'b1;
    check_eq("reset_trigger", observed(), v);

    run_instr(6'd0,  6'd32, 1'b0, 1'b0, 0, 0);            // add right after reset
    run_instr(6'd8,  6'd0,  1'b1, 1'b0, 0, 1);            // addi overflow
    run_instr(6'd9,  6'd0,  1'b1, 1'b0, 0, 2);            // addiu ignores overflow
    run_instr(6'd0,  6'd34, 1'b1, 1'b0, 0, 3);            // sub overflow
    run_instr(6'd0,  6'd36, 1'b1, 1'b0, 0, 4);            // and ignores overflow
    run_instr(6'd0,  6'd26, 1'b0, 1'b1, 0, 5);            // div by zero
    run_instr(6'd0,  6'd26, 1'b0, 1'b0, 0, 6);            // div full length
    run_instr(6'd0,  6'd24, 1'b0, 1'b1, 0, 7);            // mult ignores divby0
    run_instr(6'd63, 6'd0,  1'b1, 1'b0, 0, 8);            // invalid opcode wins over overflow
    run_instr(6'd0,  6'd1,  1'b0, 1'b0, 0, 9);            // invalid R funct
    run_instr(6'd40, 6'd5,  1'b0, 1'b0, 0, 10);           // sb
    run_instr(6'd35, 6'd0,  1'b0, 1'b0, MEM_LAT + 3, 11); // reset mid-MEMACC of lw
    run_instr(6'd0,  6'd24, 1'b0, 1'b0, MEM_LAT + 10, 12);// reset mid-MULDIV
    run_instr(6'd63, 6'd0,  1'b0, 1'b0, MEM_LAT + 2, 13); // reset during EXC_EPC
    run_instr(6'd3,  6'd0,  1'b0, 1'b0, 0, 14);           // jal

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end else if (k < 5) begin
        op = 6'd0;
        fn = 6'(r_fn[$urandom_range(0, 15)]);
      end else begin
        op = 6'(i_op[$urandom_range(0, 15)]);
        fn = 6'($urandom_range(0, 63));
      end
      run_instr(op, fn, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 11) == 0) ? -1 : 0, 100 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
